// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED panel frame buffer: geometry, address fields,
// colour-field offsets and scanner state encodings.
package led_panel_pkg;

    localparam int COLS          = 32;
    localparam int SCAN_ROWS     = 16;
    localparam int BITS          = 8;
    localparam int BASE_TIME_DEF = 4;

    localparam int COL_W       = $clog2(COLS);
    localparam int ROW_W       = $clog2(SCAN_ROWS);
    localparam int ROW_FIELD_W = ROW_W + 1;
    localparam int PLANE_W     = $clog2(BITS);
    localparam int ADDR_W      = 1 + ROW_FIELD_W + COL_W;
    localparam int DATA_W      = 3 * BITS;
    localparam int TIMER_W     = 16;

    localparam int R_OFS = 0;
    localparam int G_OFS = 8;
    localparam int B_OFS = 16;

    typedef enum logic [1:0] {
        ST_SHIFT   = 2'd0,
        ST_LATCH   = 2'd1,
        ST_DISPLAY = 2'd2,
        ST_SWAP    = 2'd3
    } scan_state_t;

    // One bit per channel of a {B,G,R} pixel for the selected BCM plane.
    function automatic logic [2:0] plane_rgb(input logic [DATA_W-1:0] data,
                                             input logic [PLANE_W-1:0] plane);
        plane_rgb = {data[B_OFS + int'(plane)],
                     data[G_OFS + int'(plane)],
                     data[R_OFS + int'(plane)]};
    endfunction

endpackage

// File: rtl/bcm_timer.sv
// Display-time counter for one BCM plane: loads BASE_TIME<<plane and flags the
// final cycle of the display window.
module bcm_timer
    import led_panel_pkg::*;
#(
    parameter int BASE_TIME = BASE_TIME_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PLANE_W-1:0] plane,
    output logic               done
);

    logic [TIMER_W-1:0] count_r;
    logic [TIMER_W-1:0] len_s;
    logic               done_r;

    assign len_s = TIMER_W'(BASE_TIME) << plane;
    assign done  = done_r;

    // Down counter; done_r is high during the cycle in which count_r is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 16'd0;
            done_r  <= 1'b0;
        end else if (load) begin
            count_r <= len_s;
            done_r  <= (len_s == 16'd1);
        end else begin
            if (count_r != 16'd0) begin
                count_r <= count_r - 16'd1;
            end else begin
                count_r <= 16'd0;
            end
            done_r <= (count_r == 16'd2);
        end
    end

endmodule

// File: rtl/panel_scanner.sv
// Read side of the double-buffered frame buffer: fetches pixels, shifts BCM
// planes into a 1/16-scan HUB75 panel and swaps buffers only at frame end.
module panel_scanner
    import led_panel_pkg::*;
#(
    parameter int BASE_TIME = BASE_TIME_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              selected_buffer,
    output logic              actual_buffer,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [2:0]        rgb1,
    output logic [2:0]        rgb2,
    output logic              sclk,
    output logic              lat,
    output logic              oe_n,
    output logic [ROW_W-1:0]  row_addr
);

    scan_state_t        state_r, state_s;
    logic [1:0]         phase_r, phase_s;
    logic [COL_W-1:0]   col_r, col_s;
    logic [ROW_W-1:0]   row_r, row_s;
    logic [PLANE_W-1:0] plane_r, plane_s;
    logic [2:0]         upper_r, upper_s;
    logic               buf_r, buf_s;
    logic [ADDR_W-1:0]  addr_r, addr_s;
    logic [2:0]         rgb1_r, rgb1_s, rgb2_r, rgb2_s;
    logic               sclk_r, sclk_s, lat_r, lat_s, oe_n_r, oe_n_s;
    logic [ROW_W-1:0]   row_addr_r, row_addr_s;
    logic               load_s;
    logic               timer_done_s;

    bcm_timer #(.BASE_TIME(BASE_TIME)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .plane (plane_r),
        .done  (timer_done_s)
    );

    // Next-state and next-output logic. rd_addr points at the upper pixel in
    // ph0 and the lower pixel in ph1, so RAM data arrives in ph1 and ph2.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        col_s      = col_r;
        row_s      = row_r;
        plane_s    = plane_r;
        upper_s    = upper_r;
        buf_s      = buf_r;
        addr_s     = addr_r;
        rgb1_s     = rgb1_r;
        rgb2_s     = rgb2_r;
        sclk_s     = 1'b0;
        lat_s      = 1'b0;
        oe_n_s     = 1'b1;
        row_addr_s = row_addr_r;
        load_s     = 1'b0;

        case (state_r)
            ST_SHIFT: begin
                phase_s = phase_r + 2'd1;
                case (phase_r)
                    2'd0: begin
                        addr_s = {buf_r, 1'b1, row_r, col_r};
                    end
                    2'd1: begin
                        upper_s = plane_rgb(rd_data, plane_r);
                    end
                    2'd2: begin
                        rgb1_s = upper_r;
                        rgb2_s = plane_rgb(rd_data, plane_r);
                        sclk_s = 1'b1;
                    end
                    2'd3: begin
                        if (col_r == COL_W'(COLS - 1)) begin
                            col_s      = COL_W'(0);
                            state_s    = ST_LATCH;
                            lat_s      = 1'b1;
                            row_addr_s = row_r;
                        end else begin
                            col_s  = col_r + COL_W'(1);
                            addr_s = {buf_r, 1'b0, row_r, col_r + COL_W'(1)};
                        end
                    end
                    default: begin
                        phase_s = 2'd0;
                    end
                endcase
            end
            ST_LATCH: begin
                oe_n_s  = 1'b0;
                load_s  = 1'b1;
                state_s = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                if (timer_done_s) begin
                    if (plane_r == PLANE_W'(BITS - 1)) begin
                        plane_s = PLANE_W'(0);
                        if (row_r == ROW_W'(SCAN_ROWS - 1)) begin
                            row_s   = ROW_W'(0);
                            state_s = ST_SWAP;
                        end else begin
                            row_s   = row_r + ROW_W'(1);
                            addr_s  = {buf_r, 1'b0, row_r + ROW_W'(1), COL_W'(0)};
                            state_s = ST_SHIFT;
                        end
                    end else begin
                        plane_s = plane_r + PLANE_W'(1);
                        addr_s  = {buf_r, 1'b0, row_r, COL_W'(0)};
                        state_s = ST_SHIFT;
                    end
                end else begin
                    oe_n_s = 1'b0;
                end
            end
            ST_SWAP: begin
                buf_s   = selected_buffer;
                addr_s  = {selected_buffer, ROW_FIELD_W'(0), COL_W'(0)};
                state_s = ST_SHIFT;
            end
            default: begin
                state_s = ST_SHIFT;
            end
        endcase
    end

    // State and output registers; async reset blanks the panel immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_SHIFT;
            phase_r    <= 2'd0;
            col_r      <= COL_W'(0);
            row_r      <= ROW_W'(0);
            plane_r    <= PLANE_W'(0);
            upper_r    <= 3'd0;
            buf_r      <= 1'b0;
            addr_r     <= ADDR_W'(0);
            rgb1_r     <= 3'd0;
            rgb2_r     <= 3'd0;
            sclk_r     <= 1'b0;
            lat_r      <= 1'b0;
            oe_n_r     <= 1'b1;
            row_addr_r <= ROW_W'(0);
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            col_r      <= col_s;
            row_r      <= row_s;
            plane_r    <= plane_s;
            upper_r    <= upper_s;
            buf_r      <= buf_s;
            addr_r     <= addr_s;
            rgb1_r     <= rgb1_s;
            rgb2_r     <= rgb2_s;
            sclk_r     <= sclk_s;
            lat_r      <= lat_s;
            oe_n_r     <= oe_n_s;
            row_addr_r <= row_addr_s;
        end
    end

    assign actual_buffer = buf_r;
    assign rd_addr       = addr_r;
    assign rgb1          = rgb1_r;
    assign rgb2          = rgb2_r;
    assign sclk          = sclk_r;
    assign lat           = lat_r;
    assign oe_n          = oe_n_r;
    assign row_addr      = row_addr_r;

endmodule

// File: tb/tb_panel_scanner.sv
// Scoreboard bench for panel_scanner: expected shift data, latch rows/buffers
// and display widths are queued by the stimulus and consumed by a monitor.
module tb_panel_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        selected_buffer;
    logic        actual_buffer;
    logic [10:0] rd_addr;
    logic [23:0] rd_data;
    logic [2:0]  rgb1, rgb2;
    logic        sclk, lat, oe_n;
    logic [3:0]  row_addr;

    logic [23:0] mem [0:2047];

    logic [5:0] exp_pix [$];
    logic [4:0] exp_lat [$];
    int         exp_oe  [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    panel_scanner dut (
        .clk             (clk),
        .rst             (rst),
        .selected_buffer (selected_buffer),
        .actual_buffer   (actual_buffer),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .rgb1            (rgb1),
        .rgb2            (rgb2),
        .sclk            (sclk),
        .lat             (lat),
        .oe_n            (oe_n),
        .row_addr        (row_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        cyc     <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hand-computed {rgb1,rgb2} for the directed pixel set loaded below.
    function automatic logic [5:0] exp_px(input logic b, input int r, input int p, input int c);
        logic [2:0] u;
        logic [2:0] l;
        u = 3'b000;
        l = 3'b000;
        if (!b) begin
            if (r == 0 && c == 5) u = 3'b001;
            if (r == 3 && c == 7 && (p == 0 || p == 2)) u = 3'b001;
            if (r == 0 && c == 0) l = 3'b100;
            if (r == 4 && c == 31 && (p == 5 || p == 7)) l = 3'b010;
        end else begin
            if (r == 0 && c == 0) u = 3'b010;
        end
        return {u, l};
    endfunction

    task automatic push_row_plane(input logic b, input int r, input int p);
        for (int c = 0; c < 32; c++) exp_pix.push_back(exp_px(b, r, p, c));
        exp_lat.push_back({b, 4'(r)});
        exp_oe.push_back(4 << p);
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_pix.size() + exp_lat.size() + exp_oe.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_pix.size() + exp_lat.size() + exp_oe.size()), 32'd0);
    endtask

    // Monitor: pops and compares on every sclk rise, lat pulse and end of oe_n window.
    logic prev_sclk = 1'b0;
    logic prev_oe   = 1'b1;
    int   run       = 0;
    int   sclk_cnt  = 0;
    int   lat_idx   = 0;
    int   t0        = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_sclk = 1'b0;
            prev_oe   = 1'b1;
            run       = 0;
            sclk_cnt  = 0;
            lat_idx   = 0;
        end else begin
            if (sclk && !prev_sclk) begin
                sclk_cnt++;
                if (exp_pix.size() > 0) check("pixel", 32'({rgb1, rgb2}), 32'(exp_pix.pop_front()));
            end
            if (lat) begin
                check("sclk_per_row", 32'(sclk_cnt), 32'd32);
                check("oe_during_lat", 32'(oe_n), 32'd1);
                sclk_cnt = 0;
                if (exp_lat.size() > 0) check("lat_buf_row", 32'({actual_buffer, row_addr}), 32'(exp_lat.pop_front()));
                if (lat_idx == 0) t0 = cyc;
                if (lat_idx == 128) check("frame_period", 32'(cyc - t0), 32'd32833);
                lat_idx++;
            end
            if (!oe_n) begin
                run++;
            end else if (!prev_oe) begin
                if (exp_oe.size() > 0) check("oe_width", 32'(run), 32'(exp_oe.pop_front()));
                run = 0;
            end
            prev_sclk = sclk;
            prev_oe   = oe_n;
        end
    end

    initial begin
        int n;
        rst             = 1'b1;
        selected_buffer = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 24'h000000;
        mem[5]    = 24'h0000FF;  // buf0 row0 col5, red
        mem[512]  = 24'hFF0000;  // buf0 row16 col0, blue
        mem[103]  = 24'h000005;  // buf0 row3 col7, red planes 0,2
        mem[671]  = 24'h00A000;  // buf0 row20 col31, green planes 5,7
        mem[1024] = 24'h00FF00;  // buf1 row0 col0, green
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_actual_buffer", 32'(actual_buffer), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_rgb", 32'({rgb1, rgb2}), 32'd0);
        check("rst_sclk_lat", 32'({sclk, lat}), 32'd0);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_row_addr", 32'(row_addr), 32'd0);

        for (int r = 0; r < 16; r++)
            for (int p = 0; p < 8; p++) push_row_plane(1'b0, r, p);
        for (int p = 0; p < 8; p++) push_row_plane(1'b1, 0, p);
        rst = 1'b0;

        // Request buffer 1 mid frame 1, then drop the request during frame 2 row 0.
        repeat (10000) @(posedge clk);
        selected_buffer = 1'b1;
        repeat (24000) @(posedge clk);
        selected_buffer = 1'b0;
        drain(6000, "drain_frames");

        // Reset during DISPLAY: oe_n must rise without a clock edge.
        n = 0;
        while (oe_n !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("found_display", 32'(oe_n), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("async_oe_n", 32'(oe_n), 32'd1);
        check("async_buf_addr", 32'({actual_buffer, rd_addr}), 32'd0);
        check("async_lat_sclk", 32'({lat, sclk}), 32'd0);
        push_row_plane(1'b0, 0, 0);
        push_row_plane(1'b0, 0, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drain(3000, "drain_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
